// File: rtl/operand_queue.sv
// Operand buffer between the VRF access stage and one VFU consumer: beat-count commands
// gate delivery of buffered words and mark instruction boundaries. Optional fall-through
// path enabled by `define OPERAND_QUEUE_BYPASS_EN.
module operand_queue #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = 8,
    parameter int unsigned CmdDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [CntWidth-1:0]  cmd_cnt_i,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [DataWidth-1:0] operand_i,
    output logic                 vfu_valid_o,
    input  logic                 vfu_ready_i,
    output logic [DataWidth-1:0] vfu_operand_o,
    output logic                 vfu_last_o,
    output logic                 idle_o
);

    localparam int unsigned DAW = $clog2(Depth);
    localparam int unsigned CPW = $clog2(CmdDepth) + 1;
    localparam int unsigned CAW = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
    localparam logic [DAW:0]   DFull = (DAW+1)'(Depth);
    localparam logic [CPW-1:0] CFull = CPW'(CmdDepth);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   rem_q, rem_d;

    logic [DataWidth-1:0]  data_mem [Depth];
    logic [DAW:0]          d_wr_ptr, d_rd_ptr;
    logic                  d_empty, d_full, d_push, d_pop;

    logic [CntWidth-1:0]   cmd_mem [CmdDepth];
    logic [CPW-1:0]        c_wr_ptr, c_rd_ptr;
    logic [CAW-1:0]        c_wr_idx, c_rd_idx;
    logic                  c_empty, c_full, c_push, c_pop;

    logic                  byp, vfu_hs;

    // Pointers carry one extra wrap bit, so the difference distinguishes full from empty.
    assign d_empty = (d_wr_ptr == d_rd_ptr);
    assign d_full  = ((d_wr_ptr - d_rd_ptr) == DFull);
    assign c_empty = (c_wr_ptr == c_rd_ptr);
    assign c_full  = ((c_wr_ptr - c_rd_ptr) == CFull);

    generate
        if (CmdDepth > 1) begin : g_cidx
            assign c_wr_idx = c_wr_ptr[CAW-1:0];
            assign c_rd_idx = c_rd_ptr[CAW-1:0];
        end else begin : g_cidx1
            assign c_wr_idx = '0;
            assign c_rd_idx = '0;
        end
    endgenerate

    assign cmd_ready_o = !c_full;
    // Zero-beat commands are acknowledged but never occupy a slot.
    assign c_push      = cmd_valid_i && !c_full && (cmd_cnt_i != '0);

`ifdef OPERAND_QUEUE_BYPASS_EN
    assign byp        = (state_q == ACTIVE) && d_empty && op_valid_i;
    assign op_ready_o = !d_full || vfu_hs;
`else
    assign byp        = 1'b0;
    assign op_ready_o = !d_full;
`endif

    assign vfu_valid_o   = (state_q == ACTIVE) && (!d_empty || byp);
    assign vfu_operand_o = !vfu_valid_o ? '0 :
                           byp          ? operand_i : data_mem[d_rd_ptr[DAW-1:0]];
    assign vfu_last_o    = vfu_valid_o && (rem_q == CntWidth'(1));
    assign vfu_hs        = vfu_valid_o && vfu_ready_i;
    assign d_pop         = vfu_hs && !d_empty;
    // A bypassed word that the VFU takes right away is never written.
    assign d_push        = op_valid_i && op_ready_o && !(byp && vfu_ready_i);

    assign idle_o = (state_q == IDLE) && c_empty && d_empty;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        c_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!c_empty) begin
                    c_pop   = 1'b1;
                    rem_d   = cmd_mem[c_rd_idx];
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vfu_hs) begin
                    if (rem_q == CntWidth'(1)) begin
                        if (!c_empty) begin
                            c_pop = 1'b1;
                            rem_d = cmd_mem[c_rd_idx];
                        end else begin
                            rem_d   = '0;
                            state_d = IDLE;
                        end
                    end else if (rem_q != '0) begin
                        rem_d = rem_q - CntWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            d_wr_ptr <= '0;
            d_rd_ptr <= '0;
            c_wr_ptr <= '0;
            c_rd_ptr <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (d_push) d_wr_ptr <= d_wr_ptr + 1'b1;
            if (d_pop)  d_rd_ptr <= d_rd_ptr + 1'b1;
            if (c_push) c_wr_ptr <= c_wr_ptr + 1'b1;
            if (c_pop)  c_rd_ptr <= c_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (d_push) data_mem[d_wr_ptr[DAW-1:0]] <= operand_i;
        if (c_push) cmd_mem[c_wr_idx] <= cmd_cnt_i;
    end

endmodule

// File: tb/tb_operand_queue.sv
// Self-checking bench for operand_queue: directed vector tables, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_operand_queue;

    localparam int Depth    = 4;
    localparam int CmdDepth = 2;
`ifdef OPERAND_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_cnt = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [63:0] operand = '0;
    logic        vfu_valid;
    logic        vfu_ready = 1'b0;
    logic [63:0] vfu_operand;
    logic        vfu_last;
    logic        idle;

    operand_queue #(.DataWidth(64), .Depth(Depth), .CntWidth(8), .CmdDepth(CmdDepth)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_cnt_i(cmd_cnt),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .operand_i(operand),
        .vfu_valid_o(vfu_valid), .vfu_ready_i(vfu_ready), .vfu_operand_o(vfu_operand),
        .vfu_last_o(vfu_last), .idle_o(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending commands, buffered words, current instruction beats left.
    int          cmdq[$];
    logic [63:0] dq[$];
    bit          m_active;
    int          m_rem;
    bit          e_valid, e_last, e_op_ready, e_cmd_ready, e_idle, e_byp;
    logic [63:0] e_operand;
    bit          s_ophs, s_vhs, s_last;
    logic [63:0] s_data;

    task automatic model_reset();
        cmdq.delete();
        dq.delete();
        m_active = 0;
        m_rem    = 0;
    endtask

    task automatic model_eval();
        e_byp       = BYP && m_active && dq.size() == 0 && op_valid;
        e_cmd_ready = cmdq.size() < CmdDepth;
        e_valid     = m_active && (dq.size() > 0 || e_byp);
        e_operand   = !e_valid ? 64'd0 : (dq.size() > 0 ? dq[0] : operand);
        e_last      = e_valid && m_rem == 1;
        e_op_ready  = dq.size() < Depth || (BYP && e_valid && vfu_ready);
        e_idle      = !m_active && cmdq.size() == 0 && dq.size() == 0;
    endtask

    task automatic model_update();
        if (e_valid && vfu_ready) begin
            if (dq.size() > 0) void'(dq.pop_front());
            m_rem--;
            if (m_rem == 0) begin
                if (cmdq.size() > 0) m_rem = cmdq.pop_front();
                else m_active = 0;
            end
        end else if (!m_active && cmdq.size() > 0) begin
            m_rem    = cmdq.pop_front();
            m_active = 1;
        end
        if (cmd_valid && e_cmd_ready && cmd_cnt != 0) cmdq.push_back(int'(cmd_cnt));
        if (op_valid && e_op_ready && !(e_byp && vfu_ready)) dq.push_back(operand);
    endtask

    // One clock: inputs were driven at the falling edge; compare, advance model, advance DUT.
    task automatic step(input bit check);
        #1;
        model_eval();
        if (check) begin
            chk("m.vfu_valid", vfu_valid, e_valid);
            chk("m.vfu_last", vfu_last, e_last);
            chk("m.vfu_operand", vfu_operand, e_operand);
            chk("m.op_ready", op_ready, e_op_ready);
            chk("m.cmd_ready", cmd_ready, e_cmd_ready);
            chk("m.idle", idle, e_idle);
        end
        s_ophs = op_valid && op_ready;
        s_vhs  = vfu_valid && vfu_ready;
        s_last = vfu_last;
        s_data = vfu_operand;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit cv, input logic [7:0] cnt, input bit ov,
                         input logic [63:0] opd, input bit rdy);
        cmd_valid = cv; cmd_cnt = cnt; op_valid = ov; operand = opd; vfu_ready = rdy;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit cv; logic [7:0] cnt; bit ov; logic [63:0] opd; bit rdy;
        bit ev; bit el; logic [63:0] eo; bit eopr; bit ecr; bit eidle;
    } vec_t;

    function automatic vec_t mk(input bit cv, input logic [7:0] cnt, input bit ov,
                                input logic [63:0] opd, input bit rdy, input bit ev,
                                input bit el, input logic [63:0] eo, input bit eopr,
                                input bit ecr, input bit eidle);
        vec_t v;
        v.cv = cv; v.cnt = cnt; v.ov = ov; v.opd = opd; v.rdy = rdy;
        v.ev = ev; v.el = el; v.eo = eo; v.eopr = eopr; v.ecr = ecr; v.eidle = eidle;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        drive(v.cv, v.cnt, v.ov, v.opd, v.rdy);
        #1;
        chk({tag, ".vfu_valid"}, vfu_valid, v.ev);
        chk({tag, ".vfu_last"}, vfu_last, v.el);
        chk({tag, ".vfu_operand"}, vfu_operand, v.eo);
        chk({tag, ".op_ready"}, op_ready, v.eopr);
        chk({tag, ".cmd_ready"}, cmd_ready, v.ecr);
        chk({tag, ".idle"}, idle, v.eidle);
        model_eval();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [63:0] WA = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] WB = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] WC = 64'hCCCC_0000_0000_0003;

    vec_t t1[6];
    vec_t t4[10];
    logic [63:0] w[6];

    initial begin
        int sent, got, nlast, lastpos, first, lastc, lastmask;

        // cmd cnt=3 then A,B,C back-to-back: beats A,B,C, last only with C, idle afterwards
        t1[0] = mk(1, 3, 0, 0,  1, 0, 0, 0,  1, 1, 1);
        t1[1] = mk(0, 0, 1, WA, 1, 0, 0, 0,  1, 1, 0);
        t1[2] = mk(0, 0, 1, WB, 1, 1, 0, WA, 1, 1, 0);
        t1[3] = mk(0, 0, 1, WC, 1, 1, 0, WB, 1, 1, 0);
        t1[4] = mk(0, 0, 0, 0,  1, 1, 1, WC, 1, 1, 0);
        t1[5] = mk(0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 1);
        // cnt=0 dropped, cnt=1 delivers one last beat; then fill the command FIFO
        t4[0] = mk(1, 0, 0, 0,  1, 0, 0, 0,  1, 1, 1);
        t4[1] = mk(1, 1, 1, WA, 1, 0, 0, 0,  1, 1, 1);
        t4[2] = mk(0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0);
        t4[3] = mk(0, 0, 0, 0,  1, 1, 1, WA, 1, 1, 0);
        t4[4] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1);
        t4[5] = mk(1, 2, 0, 0,  0, 0, 0, 0,  1, 1, 1);
        t4[6] = mk(1, 3, 0, 0,  0, 0, 0, 0,  1, 1, 0);
        t4[7] = mk(1, 4, 0, 0,  0, 0, 0, 0,  1, 1, 0);
        t4[8] = mk(1, 9, 0, 0,  0, 0, 0, 0,  1, 0, 0);
        t4[9] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0);

        reset_dut();
        for (int i = 0; i < 6; i++) run_vec(t1[i], $sformatf("t1[%0d]", i));

        reset_dut();
        for (int i = 0; i < 10; i++) run_vec(t4[i], $sformatf("t4[%0d]", i));

        // Backpressure: 4 accepted while the VFU stalls, then 6 delivered in order
        reset_dut();
        for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
        drive(1, 6, 0, 0, 0);
        step(1);
        cmd_valid = 0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            op_valid = (sent < 6);
            operand  = w[sent < 6 ? sent : 0];
            step(1);
            if (s_ophs) sent++;
        end
        chk("t2.accepted_stalled", sent, 4);
        chk("t2.op_ready_full", op_ready, 0);
        vfu_ready = 1;
        got = 0; nlast = 0; lastpos = -1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            op_valid = (sent < 6);
            operand  = w[sent < 6 ? sent : 0];
            step(1);
            if (s_ophs) sent++;
            if (s_vhs) begin
                chk($sformatf("t2.beat%0d", got), s_data, w[got]);
                if (s_last) begin nlast++; lastpos = got; end
                got++;
            end
        end
        chk("t2.beats", got, 6);
        chk("t2.num_last", nlast, 1);
        chk("t2.last_pos", lastpos, 5);

        // Back-to-back cnt=2, cnt=1: three beats with no bubble, last on beats 2 and 3
        reset_dut();
        got = 0; first = -1; lastc = -1; lastmask = 0; sent = 0;
        for (int c = 0; c < 15; c++) begin
            cmd_valid = (c < 2);
            cmd_cnt   = (c == 0) ? 8'd2 : 8'd1;
            op_valid  = (c >= 1 && sent < 3);
            operand   = w[sent < 3 ? sent : 0];
            vfu_ready = 1;
            step(1);
            if (s_ophs) sent++;
            if (s_vhs) begin
                if (first < 0) first = c;
                lastc = c;
                if (s_last) lastmask |= (1 << got);
                got++;
            end
        end
        chk("t3.beats", got, 3);
        chk("t3.no_bubble", lastc - first, 2);
        chk("t3.last_mask", lastmask, 6);
        chk("t3.idle_end", idle, 1);

        // Reset with two words buffered and an active command
        reset_dut();
        drive(1, 4, 0, 0, 0);
        step(1);
        cmd_valid = 0;
        for (int c = 0; c < 2; c++) begin
            op_valid = 1; operand = w[c];
            step(1);
        end
        op_valid = 0;
        step(1);
        chk("t5.valid_before", vfu_valid, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5.valid_in_reset", vfu_valid, 0);
        chk("t5.idle_in_reset", idle, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t5.valid_after_edge", vfu_valid, 0);
        chk("t5.idle_after_edge", idle, 1);
        chk("t5.operand_zero", vfu_operand, 0);
        rst_n = 1'b1;
        drive(1, 1, 1, WB, 1);
        step(1);
        drive(0, 0, 0, 0, 1);
        got = 0; nlast = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (s_vhs) begin
                chk("t5.data", s_data, WB);
                if (s_last) nlast++;
                got++;
            end
        end
        chk("t5.beats", got, 1);
        chk("t5.last", nlast, 1);

`ifdef OPERAND_QUEUE_BYPASS_EN
        // Same-cycle fall-through on an empty FIFO with an active command
        reset_dut();
        drive(1, 1, 0, 0, 1);
        step(1);
        drive(0, 0, 0, 0, 1);
        step(1);
        drive(0, 0, 1, WC, 1);
        #1;
        chk("t6.valid", vfu_valid, 1);
        chk("t6.last", vfu_last, 1);
        chk("t6.operand", vfu_operand, WC);
        step(1);
        op_valid = 0;
        #1;
        chk("t6.idle", idle, 1);
        chk("t6.valid_after", vfu_valid, 0);
        @(negedge clk);
`endif

        // Randomized traffic against the reference model
        reset_dut();
        for (int c = 0; c < 2000; c++) begin
            cmd_valid = ($urandom_range(0, 99) < 25);
            cmd_cnt   = 8'($urandom_range(0, 5));
            op_valid  = ($urandom_range(0, 99) < 60);
            operand   = {$urandom, $urandom};
            vfu_ready = ($urandom_range(0, 99) < 60);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
